inst_mem: RTL and testbench
===========================

INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, fetch address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of storage words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter FILL, default all-ones of DATA_W, word returned for unloaded or out-of-range addresses.
REQ-005 SHALL have port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port fetch_en_i  in  1  fetch request.
REQ-008 SHALL have port address_i  in  ADDR_W  fetch address.
REQ-009 SHALL have port instruction_o  out  DATA_W  registered fetched word.
REQ-010 SHALL have port instr_valid_o  out  1  instruction_o holds a fetch result.
REQ-011 SHALL have port load_start_i  in  1  begin or restart program load.
REQ-012 SHALL have port load_valid_i  in  1  load word offered.
REQ-013 SHALL have port load_data_i  in  DATA_W  load word.
REQ-014 SHALL have port load_last_i  in  1  offered word is final word of program.
REQ-015 SHALL have port load_ready_o  out  1  block accepts load word.
REQ-016 SHALL have port busy_o  out  1  load in progress.
REQ-017 SHALL have port load_count_o  out  ADDR_W+1  number of words loaded.
REQ-018 SHALL have port parity_err_o  out  1  fetch parity error (see Configuration).

Function
REQ-019 SHALL implement FSM states EMPTY, LOAD, RUN.
REQ-020 EMPTY -> LOAD and RUN -> LOAD on load_start_i=1; LOAD -> RUN on accepted word with load_last_i=1 or accepted word written at index DEPTH-1.
REQ-021 On entering LOAD (including load_start_i while already in LOAD), write pointer and load_count_o SHALL clear to 0.
REQ-022 load_ready_o = 1 iff state is LOAD; busy_o = 1 iff state is LOAD.
REQ-023 Accepted word (load_valid_i & load_ready_o & !load_start_i) SHALL be written at the write pointer; pointer and load_count_o increment by 1.
REQ-024 load_start_i coincident with a handshake in LOAD SHALL discard that word and restart at index 0.
REQ-025 In RUN or EMPTY, fetch_en_i=1 SHALL produce, one cycle later, instr_valid_o=1 and instruction_o = stored word if address_i < load_count_o, else FILL.
REQ-026 In EMPTY every fetch SHALL return FILL.
REQ-027 fetch_en_i=0, or state LOAD, SHALL give instr_valid_o=0 next cycle; instruction_o holds its previous value.
REQ-028 Fetch latency SHALL be exactly 1 cycle; back-to-back fetches SHALL sustain one per cycle.
REQ-029 Fetch and the load handshake cycle that completes LOAD -> RUN SHALL not interact: a fetch is only accepted in the cycle the state is already RUN.

Reset
REQ-030 rst_i=1 SHALL force state EMPTY, load_count_o=0, write pointer 0, instruction_o=FILL, instr_valid_o=0, load_ready_o=0, busy_o=0, parity_err_o=0.
REQ-031 Storage contents SHALL not be reset; load_count_o=0 guarantees all fetches return FILL.
REQ-032 rst_i during LOAD SHALL abandon the load; reset has priority over all inputs.

Configuration
REQ-033 Macro INST_MEM_PARITY_EN defined: each stored word SHALL carry an even-parity bit computed on write; a fetch of a loaded word with mismatching parity SHALL set parity_err_o=1 for the same cycle as instr_valid_o, else 0.
REQ-034 Macro undefined: no parity storage; parity_err_o SHALL be constant 0.

Verification
REQ-035 Reset, then fetch address 0x05 -> next cycle instr_valid_o=1, instruction_o=0xFF.
REQ-036 load_start, load 0xC0,0xC2,0xC3 (last on 0xC3) -> load_count_o=3, state RUN; fetch 0x01 -> 0xC2; fetch 0x03 -> 0xFF.
REQ-037 Fetch addresses 0,1,2 on consecutive cycles -> 0xC0,0xC2,0xC3 on the following three cycles, instr_valid_o held 1.
REQ-038 Mid-load (2 words in) assert load_start_i with load_valid_i=1, data 0xAA -> 0xAA discarded, load_count_o=0, busy_o=1.
REQ-039 Load DEPTH words without load_last_i -> RUN after word DEPTH-1, load_count_o=DEPTH, load_ready_o=0.
REQ-040 With INST_MEM_PARITY_EN, force a stored bit flip at address 0, fetch 0 -> parity_err_o=1 with instr_valid_o=1.

Source files
------------

// File: rtl/inst_mem.sv
// Loadable instruction memory: program words are streamed in while loading,
// then fetched with one-cycle latency. Define INST_MEM_PARITY_EN for per-word parity.
module inst_mem #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] address_i,
  output logic [DATA_W-1:0] instruction_o,
  output logic              instr_valid_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   load_count_o,
  output logic              parity_err_o,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  // Load handshake: a word transfers on a cycle where load_valid_i and
  // load_ready_o are both high; load_start_i in that cycle cancels the transfer.
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_load_count;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;

  logic w_accept;
  logic w_wr_last;
  logic w_fetch;
  logic w_hit;

  assign w_accept  = (r_state == ST_LOAD) & load_valid_i & ~load_start_i;
  assign w_wr_last = (r_wr_ptr == PTR_LAST);
  assign w_fetch   = fetch_en_i & (r_state != ST_LOAD);
  assign w_hit     = ({1'b0, address_i} < r_load_count);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_EMPTY;
      r_wr_ptr     <= '0;
      r_load_count <= '0;
    end else begin
      case (r_state)
        ST_EMPTY, ST_RUN: begin
          if (load_start_i) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= '0;
            r_load_count <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start_i) begin
            r_wr_ptr     <= '0;
            r_load_count <= '0;
          end else if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + PTR_ONE;
            r_load_count <= r_load_count + CNT_ONE;
            if (load_last_i || w_wr_last) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_wr_ptr     <= '0;
          r_load_count <= '0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a zero load count masks stale words.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      r_mem[r_wr_ptr] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr <= FILL;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_fetch;
      if (w_fetch) begin
        r_instr <= w_hit ? r_mem[address_i] : FILL;
      end
    end
  end

`ifdef INST_MEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_accept) begin
      r_par[r_wr_ptr] <= ^load_data_i;
    end
  end

  // Error flag lines up with the fetched word it describes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_fetch & w_hit & ((^r_mem[address_i]) != r_par[address_i]);
    end
  end

  assign parity_err_o = r_par_err;
`else
  assign parity_err_o = 1'b0;
`endif

  assign instruction_o = r_instr;
  assign instr_valid_o = r_valid;
  assign load_ready_o  = (r_state == ST_LOAD);
  assign busy_o        = (r_state == ST_LOAD);
  assign load_count_o  = r_load_count;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: directed vector table, hand sequences for full-depth load
// and parity, then random traffic against a queue-based program model.
module tb_inst_mem;
  localparam int          DATA_W = 8;
  localparam int          ADDR_W = 8;
  localparam int          DEPTH  = 256;
  localparam logic [7:0]  FILL   = 8'hFF;

  logic              clk;
  logic              rst;
  logic              fetch_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              busy;
  logic [ADDR_W:0]   load_count;
  logic              parity_err;
  logic [1:0]        dbg_state;

  inst_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en), .address_i(address),
    .instruction_o(instruction), .instr_valid_o(instr_valid),
    .load_start_i(load_start), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_last_i(load_last), .load_ready_o(load_ready), .busy_o(busy),
    .load_count_o(load_count), .parity_err_o(parity_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: program held as a queue of words
  int         m_mode = 0;  // 0 empty, 1 loading, 2 running
  logic [7:0] m_prog[$];
  logic [7:0] m_instr = FILL;
  logic       m_valid = 1'b0;

  task automatic model_step(input logic fe, input logic [7:0] a, input logic st,
                            input logic v, input logic [7:0] d, input logic l, input logic r);
    if (r) begin
      m_mode = 0; m_prog.delete(); m_instr = FILL; m_valid = 1'b0;
    end else begin
      m_valid = fe && (m_mode != 1);
      if (m_valid) m_instr = (int'(a) < m_prog.size()) ? m_prog[a] : FILL;
      if (m_mode == 1) begin
        if (st) m_prog.delete();
        else if (v) begin
          m_prog.push_back(d);
          if (l || m_prog.size() == DEPTH) m_mode = 2;
        end
      end else if (st) begin
        m_mode = 1; m_prog.delete();
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, sample after the edge
  task automatic drive(input logic fe, input logic [7:0] a, input logic st, input logic v,
                       input logic [7:0] d, input logic l, input logic r);
    fetch_en = fe; address = a; load_start = st; load_valid = v;
    load_data = d; load_last = l; rst = r;
    model_step(fe, a, st, v, d, l, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'(m_valid));
    check({tag, "_instr"}, 32'(instruction), 32'(m_instr));
    check({tag, "_count"}, 32'(load_count), 32'(m_prog.size()));
    check({tag, "_busy"},  32'(busy),  32'(m_mode == 1));
    check({tag, "_ready"}, 32'(load_ready), 32'(m_mode == 1));
    check({tag, "_perr"},  32'(parity_err), 32'(0));
  endtask

  typedef struct {
    logic rst; logic fe; logic [7:0] a; logic st; logic v; logic [7:0] d; logic l;
    logic ev; logic [7:0] ei; logic [8:0] ec; logic eb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic fe, input logic [7:0] a, input logic st,
                     input logic v, input logic [7:0] d, input logic l,
                     input logic ev, input logic [7:0] ei, input logic [8:0] ec, input logic eb);
    vec_t t;
    t = '{r, fe, a, st, v, d, l, ev, ei, ec, eb};
    tbl.push_back(t);
  endtask

  initial begin
    fetch_en = 0; address = 0; load_start = 0; load_valid = 0;
    load_data = 0; load_last = 0; rst = 1;

    //  rst fe addr  st v  data  l    valid instr cnt busy
    add(1, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'hFF, 0, 0);
    add(0, 1, 8'h05, 0, 0, 8'h00, 0,  1, 8'hFF, 0, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'hFF, 0, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  0, 8'hFF, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'hC0, 0,  0, 8'hFF, 1, 1);
    add(0, 0, 8'h00, 0, 1, 8'hC2, 0,  0, 8'hFF, 2, 1);
    add(0, 0, 8'h00, 0, 1, 8'hC3, 1,  0, 8'hFF, 3, 0);
    add(0, 1, 8'h01, 0, 0, 8'h00, 0,  1, 8'hC2, 3, 0);
    add(0, 1, 8'h03, 0, 0, 8'h00, 0,  1, 8'hFF, 3, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 8'hC0, 3, 0);
    add(0, 1, 8'h01, 0, 0, 8'h00, 0,  1, 8'hC2, 3, 0);
    add(0, 1, 8'h02, 0, 0, 8'h00, 0,  1, 8'hC3, 3, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'hC3, 3, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  0, 8'hC3, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'h11, 0,  0, 8'hC3, 1, 1);
    add(0, 0, 8'h00, 0, 1, 8'h22, 0,  0, 8'hC3, 2, 1);
    add(0, 0, 8'h00, 1, 1, 8'hAA, 0,  0, 8'hC3, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'h33, 1,  0, 8'hC3, 1, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 8'h33, 1, 0);
    add(0, 1, 8'h01, 0, 0, 8'h00, 0,  1, 8'hFF, 1, 0);
    add(0, 1, 8'h00, 1, 0, 8'h00, 0,  1, 8'h33, 0, 1);
    add(0, 1, 8'h00, 0, 1, 8'h44, 1,  0, 8'h33, 1, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 8'h44, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  0, 8'h44, 0, 1);
    add(0, 0, 8'h00, 0, 1, 8'h55, 0,  0, 8'h44, 1, 1);
    add(0, 0, 8'h00, 0, 0, 8'h00, 0,  0, 8'h44, 1, 1);
    add(1, 0, 8'h00, 0, 1, 8'h66, 0,  0, 8'hFF, 0, 0);
    add(0, 1, 8'h00, 0, 0, 8'h00, 0,  1, 8'hFF, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].fe, tbl[i].a, tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rst);
      check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_instr", i), 32'(instruction), 32'(tbl[i].ei));
      check($sformatf("tbl%0d_count", i), 32'(load_count),  32'(tbl[i].ec));
      check($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].eb));
      check($sformatf("tbl%0d_ready", i), 32'(load_ready),  32'(tbl[i].eb));
      check($sformatf("tbl%0d_perr", i),  32'(parity_err),  32'(0));
    end

    // full-depth load with no last marker
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 1, 8'(i) ^ 8'h5A, 0, 0);
      if (i == DEPTH - 2) begin
        check("full_count_pre", 32'(load_count), 32'(DEPTH - 1));
        check("full_busy_pre", 32'(busy), 32'(1));
      end
    end
    check("full_count", 32'(load_count), 32'(DEPTH));
    check("full_ready", 32'(load_ready), 32'(0));
    check("full_busy", 32'(busy), 32'(0));
    check("full_state", 32'(dbg_state), 32'(2));
    drive(1, 8'hFF, 0, 0, 0, 0, 0);
    check("full_last_word", 32'(instruction), 32'(8'hA5));
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    check("full_first_word", 32'(instruction), 32'(8'h5A));
    check("full_first_valid", 32'(instr_valid), 32'(1));

`ifdef INST_MEM_PARITY_EN
    dut.r_mem[0] = dut.r_mem[0] ^ 8'h01;
    drive(1, 8'h00, 0, 0, 0, 0, 0);
    check("par_err", 32'(parity_err), 32'(1));
    check("par_valid", 32'(instr_valid), 32'(1));
    drive(1, 8'h01, 0, 0, 0, 0, 0);
    check("par_clean", 32'(parity_err), 32'(0));
`endif

    // randomized traffic against the model
    drive(0, 0, 0, 0, 0, 0, 1);
    check_model("rnd_rst");
    for (int c = 0; c < 4000; c++) begin
      logic       r_rst, r_fe, r_st, r_v, r_l;
      logic [7:0] r_a, r_d;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 59) == 0);
      r_v   = ($urandom_range(0, 9) < 6);
      r_l   = ($urandom_range(0, 19) == 0);
      r_fe  = ($urandom_range(0, 9) < 7);
      r_a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      r_d   = 8'($urandom);
      drive(r_fe, r_a, r_st, r_v, r_d, r_l, r_rst);
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
